// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register-memory slave: response codes and
// the write/read channel FSM states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Maps a byte address onto the memory window: in-range flag plus word index.
module axi_lite_addr_decode #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0000_1000),
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range_c,
  output logic [IDX_W-1:0]      index_c
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * (DATA_WIDTH / 8));

  logic [ADDR_WIDTH-1:0] offset_c;

  // Extra MSB on the span compare so BASE_ADDR + SPAN cannot wrap.
  assign offset_c   = addr - BASE_ADDR;
  assign in_range_c = (addr >= BASE_ADDR) && ({1'b0, offset_c} < SPAN);
  assign index_c    = IDX_W'(offset_c >> OFF_W);

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave terminating all five channels on a byte-enabled register
// memory; out-of-window accesses return SLVERR without side effects.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0000_1000),
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_W-1:0]     WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  rvalid_q, rvalid_d;
  resp_t                 rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  logic                  wr_in_range_c, rd_in_range_c;
  logic [IDX_W-1:0]      wr_index_c, rd_index_c;

  // Ready outputs are gated by reset directly so they drop in the reset cycle itself.
  assign AWREADY = areset_n && (wr_state_q == W_COLLECT) && !aw_full_q;
  assign WREADY  = areset_n && (wr_state_q == W_COLLECT) && !w_full_q;
  assign ARREADY = areset_n && (rd_state_q == R_IDLE);
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs_c   = AWVALID && AWREADY;
  assign w_hs_c    = WVALID && WREADY;
  assign ar_hs_c   = ARVALID && ARREADY;
  assign wr_addr_c = aw_full_q ? aw_addr_q : AWADDR;
  assign wr_data_c = w_full_q ? w_data_q : WDATA;
  assign wr_strb_c = w_full_q ? w_strb_q : WSTRB;

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_wr_decode (
    .addr(wr_addr_c), .in_range_c(wr_in_range_c), .index_c(wr_index_c)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_rd_decode (
    .addr(ARADDR), .in_range_c(rd_in_range_c), .index_c(rd_index_c)
  );

  // Write channel: collect AW and W in any order, commit, then hold B.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    aw_addr_d  = aw_hs_c ? AWADDR : aw_addr_q;
    w_data_d   = w_hs_c ? WDATA : w_data_q;
    w_strb_d   = w_hs_c ? WSTRB : w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_d      = mem_q;
    unique case (wr_state_q)
      W_COLLECT: begin
        if ((aw_full_q || aw_hs_c) && (w_full_q || w_hs_c)) begin
          if (wr_in_range_c) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb_c[b]) mem_d[wr_index_c][8*b +: 8] = wr_data_c[8*b +: 8];
            end
            bresp_d = OKAY;
          end else begin
            bresp_d = SLVERR;
          end
          bvalid_d   = 1'b1;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          wr_state_d = W_RESP;
        end else begin
          aw_full_d = aw_full_q || aw_hs_c;
          w_full_d  = w_full_q || w_hs_c;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_COLLECT;
        end
      end
      default: wr_state_d = W_COLLECT;
    endcase
  end

  // Read channel: one registered beat per AR; reads see pre-commit memory.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rdata_d    = rd_in_range_c ? mem_q[rd_index_c] : '0;
          rresp_d    = rd_in_range_c ? OKAY : SLVERR;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      mem_q      <= '{default: '0};
      wr_state_q <= W_COLLECT;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rd_state_q <= R_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
